alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//   Shares the single ALU (alu_control + ALU datapath) between two requesters,
//   e.g. the execute stage (req0) and the branch/address unit (req1).
//   Round-robin grant, valid/ready on both sides, operands and ALU control
//   fields registered before they reach the ALU, result returned with the
//   requester ID.
// PARAMETERS
//   XLEN        32   operand/result width
// PORTS
//   clk            in   1     system clock; all state updates on posedge
//   rst            in   1     synchronous, active-high reset
//   reqN_valid     in   1     requester N (N=0,1) has an operation
//   reqN_ready     out  1     operation of requester N accepted this cycle
//   reqN_aluop     in   2     ALUOp code (00 add, 01 sub, 10 R/I-type, 11 lui)
//   reqN_funct3    in   3     funct3 field
//   reqN_funct7_5  in   1     funct7 bit 5
//   reqN_a         in   XLEN  operand A
//   reqN_b         in   XLEN  operand B
//   alu_aluop      out  2     to alu_control ALUOp (registered)
//   alu_funct3     out  3     to alu_control funct3 (registered)
//   alu_funct7_5   out  1     to alu_control funct7_5 (registered)
//   alu_a          out  XLEN  to ALU operand A (registered)
//   alu_b          out  XLEN  to ALU operand B (registered)
//   alu_result     in   XLEN  ALU result (combinational from alu_* outputs)
//   alu_zero       in   1     ALU zero flag
//   rsp_valid      out  1     response available
//   rsp_ready      in   1     consumer accepts response
//   rsp_id         out  1     requester that owns the response
//   rsp_result     out  XLEN  captured ALU result
//   rsp_zero       out  1     captured ALU zero flag
// BEHAVIOUR
//   - FSM: IDLE -> EXEC -> RESP -> IDLE. One operation in flight.
//   - IDLE: if any reqN_valid, grant one; reqN_ready=1 combinationally for the
//     granted requester only; latch its aluop/funct3/funct7_5/a/b into the alu_*
//     registers and the ID; go EXEC. No valid: stay IDLE.
//   - Arbitration: one valid -> grant it. Both valid -> grant the requester NOT
//     granted last (last_grant reg). last_grant updates on every grant.
//   - EXEC: alu_* stable from registers; at end of cycle capture alu_result,
//     alu_zero into rsp_result/rsp_zero; go RESP.
//   - RESP: rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready, then IDLE.
//   - reqN_ready is 0 in EXEC and RESP; no accept in the RESP handshake cycle.
//   - Latency: accept at cycle T -> rsp_valid high from T+2. Max throughput
//     one op per 3 cycles.
//   - alu_* outputs hold the last granted operation outside EXEC (no toggling).
//   - Reset: state=IDLE, last_grant=1 (req0 wins first tie), alu_*=0,
//     rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, reqN_ready=0 during rst.
//   - Reset mid-operation (EXEC or RESP): operation dropped, no response.
//   - Requester must hold valid and fields until ready; arbiter does not check.
// TESTING
//   1 req0 aluop=00 a=5 b=3, rsp_ready=1 -> req0_ready at T, rsp_valid T+2,
//     rsp_id=0, rsp_result=8, rsp_zero=0.
//   2 req1 aluop=10 funct3=000 funct7_5=1 a=7 b=7 -> rsp_id=1, result=0, zero=1.
//   3 req0,req1 valid continuously after reset -> grants 0,1,0,1; responses
//     every 3 cycles with alternating rsp_id.
//   4 rsp_ready=0 for 4 cycles in RESP -> rsp_* unchanged, reqN_ready=0,
//     response completes on cycle rsp_ready rises, IDLE next.
//   5 rst asserted in EXEC -> rsp_valid never rises; after release with both
//     valid, req0 granted first; all outputs 0 during reset.
//   6 alu_* outputs checked: equal latched request fields through EXEC/RESP
//     while requester changes its input fields.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one ALU (alu_control + ALU datapath) between two requesters, for
// example the execute stage (req0) and the branch/address unit (req1).
// Only one operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake for requester N (0, 1);
//                                  ready is combinational, high only in IDLE
//                                  and only for the requester being granted
//   reqN_aluop/funct3/funct7_5     ALU control fields of the request
//   reqN_a / reqN_b                operands of the request
//   alu_aluop/funct3/funct7_5      registered control fields to alu_control
//   alu_a / alu_b                  registered operands to the ALU
//   alu_result / alu_zero          combinational ALU outputs, sampled in EXEC
//   rsp_valid / rsp_ready          response handshake
//   rsp_id                         requester that owns the response
//   rsp_result / rsp_zero          captured ALU result and zero flag
//
// An accept in cycle T gives rsp_valid from T+2. Peak rate is one operation
// every three cycles.

module alu_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_aluop,
  input  logic [2:0]      req0_funct3,
  input  logic            req0_funct7_5,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_aluop,
  input  logic [2:0]      req1_funct3,
  input  logic            req1_funct7_5,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,

  output logic [1:0]      alu_aluop,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7_5,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,

  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            id_q, id_d;
  logic [1:0]      aluop_q, aluop_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            funct7_5_q, funct7_5_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;

  logic            accept;
  logic            sel1;

  // Round-robin pick: req1 wins when alone, or on a tie when req0 went last.
  always_comb begin
    sel1 = req1_valid && (!req0_valid || (last_grant_q == 1'b0));
  end

  // Ready is gated by rst so nothing looks accepted while reset is applied.
  always_comb begin
    accept     = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !sel1;
    req1_ready = accept && sel1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    aluop_d      = aluop_q;
    funct3_d     = funct3_q;
    funct7_5_d   = funct7_5_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_grant_d = sel1;
          id_d         = sel1;
          if (sel1) begin
            aluop_d    = req1_aluop;
            funct3_d   = req1_funct3;
            funct7_5_d = req1_funct7_5;
            a_d        = req1_a;
            b_d        = req1_b;
          end else begin
            aluop_d    = req0_aluop;
            funct3_d   = req0_funct3;
            funct7_5_d = req0_funct7_5;
            a_d        = req0_a;
            b_d        = req0_b;
          end
          state_d = StExec;
        end
      end
      StExec: begin
        // ALU inputs have been stable from registers for the whole cycle.
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;  // req0 wins the first tie
      id_q         <= 1'b0;
      aluop_q      <= '0;
      funct3_q     <= '0;
      funct7_5_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      aluop_q      <= aluop_d;
      funct3_q     <= funct3_d;
      funct7_5_q   <= funct7_5_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  always_comb begin
    alu_aluop    = aluop_q;
    alu_funct3   = funct3_q;
    alu_funct7_5 = funct7_5_q;
    alu_a        = a_q;
    alu_b        = b_q;
    rsp_valid    = (state_q == StResp);
    rsp_id       = id_q;
    rsp_result   = rsp_result_q;
    rsp_zero     = rsp_zero_q;
  end

endmodule
